// File: rtl/bin2bcd_arb.sv
// ============================================================================
// bin2bcd_arb
// ----------------------------------------------------------------------------
// Round-robin arbiter/sequencer that shares one 32-bit binary-to-BCD converter
// among N requesters. One requester is granted at a time. Its operand is
// latched into conv_bin, the converter is started with a one-cycle conv_en
// strobe, and the 10-digit result is captured on conv_fin. The result is then
// returned with a one-cycle done pulse to the served requester.
//
// Transaction timeline (cycle 0 = idle cycle in which req is sampled):
//   cycle 1       S_START : conv_en high, gnt one-hot
//   cycles 2..    S_WAIT  : waiting for conv_fin (normally in cycle 34)
//   cycle 35      S_DONE  : done[idx] high, bcd_out valid, gnt already zero
//   cycle 36      S_IDLE  : next arbitration
//
// If conv_fin never arrives, a watchdog ends S_WAIT after 63 cycles. In that
// case bcd_out is loaded with all-ones, which can never be a legal BCD value.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      asynchronous active-low reset
//   req        in   N      per-requester request, held until matching done
//   bin        in   32*N   operand of requester i at [32*i+31:32*i]
//   gnt        out  N      one-hot grant while a transaction is in flight
//   done       out  N      one-cycle completion pulse to served requester
//   bcd_out    out  40     captured digits, digit k at [4k+3:4k]
//   busy       out  1      arbiter not idle
//   conv_en    out  1      converter start strobe
//   conv_bin   out  32     converter operand
//   conv_bcd   in   40     converter digits {bcd9..bcd0}
//   conv_busy  in   1      converter busy
//   conv_fin   in   1      converter finish pulse
// ============================================================================
module bin2bcd_arb #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N-1:0]      req,
    input  logic [32*N-1:0]   bin,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      done,
    output logic [39:0]       bcd_out,
    output logic              busy,
    output logic              conv_en,
    output logic [31:0]       conv_bin,
    input  logic [39:0]       conv_bcd,
    input  logic              conv_busy,
    input  logic              conv_fin
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Power-of-two width covering every index value, used for exact-width
    // indexing of request/one-hot vectors.
    localparam int          NP       = 1 << IW;
    localparam logic [39:0] ERR_MARK = 40'hFF_FFFF_FFFF;
    localparam logic [5:0]  WD_LIMIT = 6'd63;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // (v + k) mod N for v, k < N; one conditional subtract is enough.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v,
                                               input logic [IW:0]   k);
        logic [IW:0] sum;
        sum = {1'b0, v} + k;
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    // First requester at or after pointer p, scanning upward modulo N.
    function automatic logic [IW-1:0] pick_winner(input logic [N-1:0]  r,
                                                  input logic [IW-1:0] p);
        logic [NP-1:0] r_ext;
        logic [IW-1:0] cand;
        logic [IW-1:0] win;
        logic          found;
        r_ext = NP'(r);
        win   = {IW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = wrap_inc(p, (IW+1)'(k));
            if (!found && r_ext[cand]) begin
                win   = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // One-hot N-bit vector with bit s set.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] s);
        logic [NP-1:0] v;
        v = {{(NP-1){1'b0}}, 1'b1} << s;
        return v[N-1:0];
    endfunction

    // 32-bit operand slice of requester s.
    function automatic logic [31:0] sel_operand(input logic [32*N-1:0] b,
                                                input logic [IW-1:0]   s);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < N; i++) begin
            r = (s == IW'(i)) ? b[32*i +: 32] : r;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t          state_q,    state_d;
    logic [N-1:0]    gnt_q,      gnt_d;
    logic [N-1:0]    done_q,     done_d;
    logic [39:0]     bcd_out_q,  bcd_out_d;
    logic            conv_en_q,  conv_en_d;
    logic [31:0]     conv_bin_q, conv_bin_d;
    logic [IW-1:0]   p_q,        p_d;
    logic [IW-1:0]   idx_q,      idx_d;
    logic [5:0]      wd_q,       wd_d;

    logic [IW-1:0]   winner_s;
    logic            req_any_s;

    // Arbitration result for the current request vector and pointer.
    always_comb begin
        req_any_s = |req;
        winner_s  = pick_winner(req, p_q);
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = {N{1'b0}};
        bcd_out_d  = bcd_out_q;
        conv_en_d  = 1'b0;
        conv_bin_d = conv_bin_q;
        p_d        = p_q;
        idx_d      = idx_q;
        wd_d       = wd_q;

        case (state_q)
            S_IDLE: begin
                // A still-draining converter blocks a new grant.
                if (req_any_s && !conv_busy) begin
                    idx_d      = winner_s;
                    conv_bin_d = sel_operand(bin, winner_s);
                    gnt_d      = onehot(winner_s);
                    // conv_en is registered, so raising it here makes it
                    // high exactly during the S_START cycle.
                    conv_en_d  = 1'b1;
                    state_d    = S_START;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            S_START: begin
                // Watchdog counts S_WAIT cycles including the current one.
                wd_d    = 6'd1;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // conv_bcd is valid only in the conv_fin cycle.
                if (conv_fin) begin
                    bcd_out_d = conv_bcd;
                    done_d    = onehot(idx_q);
                    gnt_d     = {N{1'b0}};
                    state_d   = S_DONE;
                end else if (wd_q == WD_LIMIT) begin
                    bcd_out_d = ERR_MARK;
                    done_d    = onehot(idx_q);
                    gnt_d     = {N{1'b0}};
                    state_d   = S_DONE;
                end else begin
                    wd_d      = wd_q + 6'd1;
                    state_d   = S_WAIT;
                end
            end

            S_DONE: begin
                // Served requester drops to lowest priority.
                p_d     = wrap_inc(idx_q, {{IW{1'b0}}, 1'b1});
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            gnt_q      <= {N{1'b0}};
            done_q     <= {N{1'b0}};
            bcd_out_q  <= 40'd0;
            conv_en_q  <= 1'b0;
            conv_bin_q <= 32'd0;
            p_q        <= {IW{1'b0}};
            idx_q      <= {IW{1'b0}};
            wd_q       <= 6'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            bcd_out_q  <= bcd_out_d;
            conv_en_q  <= conv_en_d;
            conv_bin_q <= conv_bin_d;
            p_q        <= p_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign bcd_out  = bcd_out_q;
    assign conv_en  = conv_en_q;
    assign conv_bin = conv_bin_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bin2bcd_arb.sv
// ============================================================================
// tb_bin2bcd_arb
// Directed bench for bin2bcd_arb with a behavioural converter: it starts on
// conv_en, is busy for 32 cycles, then pulses conv_fin with the digits for one
// cycle. stub_no_fin suppresses conv_fin to exercise the watchdog.
// ============================================================================
module tb_bin2bcd_arb;
    localparam int N  = 4;
    localparam int IW = 3;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    req;
    logic [32*N-1:0] bin;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [39:0]     bcd_out;
    logic            busy;
    logic            conv_en;
    logic [31:0]     conv_bin;
    logic [39:0]     conv_bcd;
    logic            conv_busy;
    logic            conv_fin;

    logic            stub_no_fin;
    logic [31:0]     m_opnd;
    int              m_cnt;

    int              n_cmp;
    int              n_bad;

    bin2bcd_arb #(.N(N), .IW(IW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .bin       (bin),
        .gnt       (gnt),
        .done      (done),
        .bcd_out   (bcd_out),
        .busy      (busy),
        .conv_en   (conv_en),
        .conv_bin  (conv_bin),
        .conv_bcd  (conv_bcd),
        .conv_busy (conv_busy),
        .conv_fin  (conv_fin)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Decimal digits of v, used only to generate converter output.
    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [31:0] t;
        logic [39:0] r;
        t = v;
        r = 40'd0;
        for (int d = 0; d < 10; d++) begin
            r[4*d +: 4] = 4'(t % 32'd10);
            t = t / 32'd10;
        end
        return r;
    endfunction

    // Behavioural converter sharing the arbiter's reset.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            conv_busy <= 1'b0;
            conv_fin  <= 1'b0;
            conv_bcd  <= 40'd0;
            m_cnt     <= 0;
            m_opnd    <= 32'd0;
        end else begin
            conv_fin <= 1'b0;
            conv_bcd <= 40'd0;
            if (conv_en) begin
                conv_busy <= 1'b1;
                m_cnt     <= 1;
                m_opnd    <= conv_bin;
            end else if (conv_busy) begin
                if (m_cnt == 32) begin
                    conv_busy <= 1'b0;
                    if (!stub_no_fin) begin
                        conv_fin <= 1'b1;
                        conv_bcd <= to_bcd(m_opnd);
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic set_bin(input int i, input logic [31:0] v);
        bin[32*i +: 32] = v;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL reset_done got %b exp 0000", done); end
        n_cmp++; if (conv_en !== 1'b0) begin n_bad++; $display("FAIL reset_conv_en got %b exp 0", conv_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (conv_bin !== 32'd0) begin n_bad++; $display("FAIL reset_conv_bin got %h exp 0", conv_bin); end
        n_cmp++; if (bcd_out !== 40'd0) begin n_bad++; $display("FAIL reset_bcd_out got %h exp 0", bcd_out); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] exp_gnt;
        @(posedge CLK); #1;
        set_bin(0, 32'd12345678);
        req = 4'b0001;
        for (int c = 0; c <= 37; c++) begin
            @(negedge CLK);
            exp_gnt = (c >= 1 && c <= 34) ? 4'b0001 : 4'b0000;
            n_cmp++; if (gnt !== exp_gnt) begin n_bad++; $display("FAIL single_gnt c=%0d got %b exp %b", c, gnt, exp_gnt); end
            n_cmp++; if (conv_en !== (c == 1)) begin n_bad++; $display("FAIL single_conv_en c=%0d got %b exp %b", c, conv_en, (c == 1)); end
            n_cmp++; if (done !== ((c == 35) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL single_done c=%0d got %b", c, done); end
            n_cmp++; if (busy !== (c >= 1 && c <= 35)) begin n_bad++; $display("FAIL single_busy c=%0d got %b", c, busy); end
            if (c == 1) begin
                n_cmp++; if (conv_bin !== 32'd12345678) begin n_bad++; $display("FAIL single_conv_bin got %0d exp 12345678", conv_bin); end
            end
            if (c == 35) begin
                n_cmp++; if (bcd_out !== 40'h0012345678) begin n_bad++; $display("FAIL single_bcd got %h exp 0012345678", bcd_out); end
                req = 4'b0000;
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] v   [2];
        logic [39:0] exp [2];
        int          lat;
        v[0] = 32'hFFFF_FFFF; exp[0] = 40'h42_9496_7295;
        v[1] = 32'd0;         exp[1] = 40'h00_0000_0000;
        for (int t = 0; t < 2; t++) begin
            @(posedge CLK); #1;
            set_bin(1, v[t]);
            req = 4'b0010;
            lat = -1;
            for (int c = 0; c < 100; c++) begin
                @(negedge CLK);
                if (done !== 4'b0000) begin
                    lat = c;
                    n_cmp++; if (done !== 4'b0010) begin n_bad++; $display("FAIL extreme_done t=%0d got %b exp 0010", t, done); end
                    n_cmp++; if (bcd_out !== exp[t]) begin n_bad++; $display("FAIL extreme_bcd t=%0d got %h exp %h", t, bcd_out, exp[t]); end
                    req = 4'b0000;
                    break;
                end
            end
            n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL extreme_latency t=%0d got %0d exp 35", t, lat); end
            req = 4'b0000;
        end
    endtask

    task automatic test_contention();
        logic [39:0] exp_b [4];
        int          k;
        exp_b[0] = 40'h1; exp_b[1] = 40'h22; exp_b[2] = 40'h333; exp_b[3] = 40'h4444;
        do_reset();
        @(posedge CLK); #1;
        set_bin(0, 32'd1); set_bin(1, 32'd22); set_bin(2, 32'd333); set_bin(3, 32'd4444);
        req = 4'b1111;
        k = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge CLK);
            if (done !== 4'b0000) begin
                if (k < 4) begin
                    n_cmp++; if (done !== (4'b0001 << k)) begin n_bad++; $display("FAIL contention_order k=%0d got %b exp %b", k, done, 4'b0001 << k); end
                    n_cmp++; if (c != 35 + 36*k) begin n_bad++; $display("FAIL contention_time k=%0d got %0d exp %0d", k, c, 35 + 36*k); end
                    n_cmp++; if (bcd_out !== exp_b[k]) begin n_bad++; $display("FAIL contention_bcd k=%0d got %h exp %h", k, bcd_out, exp_b[k]); end
                end
                req = req & ~done;
                k++;
            end
        end
        n_cmp++; if (k != 4) begin n_bad++; $display("FAIL contention_count got %0d exp 4", k); end
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_oh [4];
        logic [39:0] exp_b  [4];
        int          k;
        exp_oh[0] = 4'b0010; exp_b[0] = 40'h7;
        exp_oh[1] = 4'b0100; exp_b[1] = 40'h2024;
        exp_oh[2] = 4'b0001; exp_b[2] = 40'h99;
        exp_oh[3] = 4'b0010; exp_b[3] = 40'h7;
        do_reset();
        @(posedge CLK); #1;
        set_bin(0, 32'd99); set_bin(1, 32'd7); set_bin(2, 32'd2024);
        req = 4'b0010;
        k = 0;
        for (int c = 0; c < 160; c++) begin
            @(negedge CLK);
            if (done !== 4'b0000) begin
                if (k < 4) begin
                    n_cmp++; if (done !== exp_oh[k]) begin n_bad++; $display("FAIL fair_order k=%0d got %b exp %b", k, done, exp_oh[k]); end
                    n_cmp++; if (c != 35 + 36*k) begin n_bad++; $display("FAIL fair_time k=%0d got %0d exp %0d", k, c, 35 + 36*k); end
                    n_cmp++; if (bcd_out !== exp_b[k]) begin n_bad++; $display("FAIL fair_bcd k=%0d got %h exp %h", k, bcd_out, exp_b[k]); end
                end
                // Requester 1 keeps its request held after its first service.
                if (k == 0) req = 4'b0111;
                else        req = req & ~done;
                k++;
            end
        end
        n_cmp++; if (k != 4) begin n_bad++; $display("FAIL fair_count got %0d exp 4", k); end
        req = 4'b0000;
    endtask

    task automatic test_watchdog();
        int lat;
        do_reset();
        stub_no_fin = 1'b1;
        @(posedge CLK); #1;
        set_bin(2, 32'd5);
        req = 4'b0100;
        lat = -1;
        for (int c = 0; c < 120; c++) begin
            @(negedge CLK);
            if (c == 64) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wd_busy_c64 got %b exp 1", busy); end
            end
            if (done !== 4'b0000) begin
                lat = c;
                n_cmp++; if (done !== 4'b0100) begin n_bad++; $display("FAIL wd_done got %b exp 0100", done); end
                n_cmp++; if (bcd_out !== 40'hFF_FFFF_FFFF) begin n_bad++; $display("FAIL wd_bcd got %h exp ffffffffff", bcd_out); end
                req = 4'b0000;
                break;
            end
        end
        n_cmp++; if (lat != 65) begin n_bad++; $display("FAIL wd_latency got %0d exp 65", lat); end
        req = 4'b0000;
        @(negedge CLK);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_idle_busy got %b exp 0", busy); end
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL wd_idle_gnt got %b exp 0000", gnt); end
        stub_no_fin = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(posedge CLK); #1;
        set_bin(1, 32'd777);
        req = 4'b0010;
        for (int c = 0; c <= 20; c++) begin
            @(negedge CLK);
            if (c == 20) begin
                n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_gnt_before got %b exp 0010", gnt); end
                RST = 1'b0;
            end
        end
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL mid_gnt got %b exp 0000", gnt); end
        n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL mid_done got %b exp 0000", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_cmp++; if (bcd_out !== 40'd0) begin n_bad++; $display("FAIL mid_bcd got %h exp 0", bcd_out); end
        n_cmp++; if (conv_en !== 1'b0) begin n_bad++; $display("FAIL mid_conv_en got %b exp 0", conv_en); end
        n_cmp++; if (dut.p_q !== 3'd0) begin n_bad++; $display("FAIL mid_ptr got %0d exp 0", dut.p_q); end
        req = 4'b0000;
        @(negedge CLK);
        n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL mid_done_hold got %b exp 0000", done); end
        RST = 1'b1;
        @(posedge CLK); #1;
        set_bin(2, 32'd90210);
        req = 4'b0100;
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (done !== 4'b0000) begin
                lat = c;
                n_cmp++; if (done !== 4'b0100) begin n_bad++; $display("FAIL mid_fresh_done got %b exp 0100", done); end
                n_cmp++; if (bcd_out !== 40'h90210) begin n_bad++; $display("FAIL mid_fresh_bcd got %h exp 0000090210", bcd_out); end
                req = 4'b0000;
                break;
            end
        end
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL mid_fresh_latency got %0d exp 35", lat); end
        req = 4'b0000;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        RST         = 1'b0;
        req         = 4'b0000;
        bin         = '0;
        stub_no_fin = 1'b0;
        test_reset();
        test_single();
        test_extremes();
        test_contention();
        test_fairness();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got hang exp finish");
        $fatal(1, "timeout");
    end

endmodule
